// File: rtl/dmem_pkg.sv
// Shared types and lane-merge helper for the data-memory RMW controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    MT_WORD = 2'b00,
    MT_BYTE = 2'b01,
    MT_HALF = 2'b10
  } memtype_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RMW_RD  = 2'b01,
    RMW_WR  = 2'b10,
    LD_WAIT = 2'b11
  } rmw_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Encoding 2'b11 is treated as a full word access.
  function automatic memtype_t decode_memtype(input logic [1:0] code);
    memtype_t mt;
    case (code)
      2'b01:   mt = MT_BYTE;
      2'b10:   mt = MT_HALF;
      default: mt = MT_WORD;
    endcase
    return mt;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_data,
                                              input memtype_t    mt,
                                              input logic [1:0]  offset);
    logic [31:0]               lane_data;
    logic [BYTES_PER_WORD-1:0] mask;
    logic [31:0]               merged;
    case (mt)
      MT_BYTE: begin
        lane_data = {4{new_data[7:0]}};
        mask      = 4'b0001 << offset;
      end
      MT_HALF: begin
        lane_data = {2{new_data[15:0]}};
        mask      = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = new_data;
        mask      = 4'b1111;
      end
    endcase
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      merged[8*i +: 8] = mask[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load-data lane select plus sign/zero extension (purely combinational).
module load_ext
  import dmem_pkg::*;
(
  input  memtype_t    memtype,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = word;
    case (memtype)
      MT_BYTE: begin
        case (offset)
          2'b00:   byte_s = word[7:0];
          2'b01:   byte_s = word[15:8];
          2'b10:   byte_s = word[23:16];
          default: byte_s = word[31:24];
        endcase
        result = {{24{~is_unsigned & byte_s[7]}}, byte_s};
      end
      MT_HALF: begin
        if (offset[1]) begin
          half_s = word[31:16];
        end else begin
          half_s = word[15:0];
        end
        result = {{16{~is_unsigned & half_s[15]}}, half_s};
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access controller: single-cycle word stores, two-cycle RMW for
// sub-word stores, one-wait loads. Define DMEM_MISALIGN_CHK_EN to drop misaligned requests.
module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [1:0]            memtype_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  stall_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rdata_valid_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [WIDTH-1:0]      mem_wd_o,
  input  logic [WIDTH-1:0]      mem_rd_i
);

  rmw_state_t            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WIDTH-1:0]      wdata_r;
  memtype_t              memtype_r;
  logic                  unsigned_r;
  logic [WIDTH-1:0]      merged_r;

  memtype_t              mt_s;
  logic                  req_s;
  logic                  misalign_s;
  logic                  word_store_s;
  logic [WIDTH-1:0]      ext_s;

  // Gating with reset keeps every output low while reset is held.
  assign req_s        = req_valid_i & rstn_i;
  assign mt_s         = decode_memtype(memtype_i);
  assign word_store_s = req_we_i & (mt_s == MT_WORD);

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign_s = ((mt_s == MT_HALF) & addr_i[0]) |
                      ((mt_s == MT_WORD) & (addr_i[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  load_ext u_load_ext (
    .memtype     (memtype_r),
    .is_unsigned (unsigned_r),
    .offset      (addr_r[1:0]),
    .word        (mem_rd_i),
    .result      (ext_s)
  );

  // Output decode from state; IDLE outputs follow the request combinationally.
  always_comb begin
    stall_o       = 1'b0;
    rdata_o       = {WIDTH{1'b0}};
    rdata_valid_o = 1'b0;
    misalign_o    = 1'b0;
    mem_addr_o    = {ADDR_WIDTH{1'b0}};
    mem_re_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_wd_o      = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_s && misalign_s) begin
          misalign_o = 1'b1;
        end else if (req_s && word_store_s) begin
          mem_we_o   = 1'b1;
          mem_wd_o   = wdata_i;
          mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (req_s) begin
          mem_re_o   = 1'b1;
          stall_o    = 1'b1;
          mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else begin
          stall_o = 1'b0;
        end
      end
      RMW_RD: begin
        stall_o    = 1'b1;
        mem_addr_o = {addr_r[ADDR_WIDTH-1:2], 2'b00};
      end
      RMW_WR: begin
        mem_we_o   = 1'b1;
        mem_wd_o   = merged_r;
        mem_addr_o = {addr_r[ADDR_WIDTH-1:2], 2'b00};
      end
      LD_WAIT: begin
        rdata_o       = ext_s;
        rdata_valid_o = 1'b1;
        mem_addr_o    = {addr_r[ADDR_WIDTH-1:2], 2'b00};
      end
      default: stall_o = 1'b0;
    endcase
  end

  // Request latching and state sequencing; a new request in RMW_WR is dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= IDLE;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {WIDTH{1'b0}};
      memtype_r  <= MT_WORD;
      unsigned_r <= 1'b0;
      merged_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i && !misalign_s && !word_store_s) begin
            addr_r     <= addr_i;
            wdata_r    <= wdata_i;
            memtype_r  <= mt_s;
            unsigned_r <= unsigned_i;
            state_r    <= req_we_i ? RMW_RD : LD_WAIT;
          end
        end
        RMW_RD: begin
          merged_r <= merge_lanes(mem_rd_i, wdata_r, memtype_r, addr_r[1:0]);
          state_r  <= RMW_WR;
        end
        RMW_WR:  state_r <= IDLE;
        LD_WAIT: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
